// File: rtl/spi_ram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spi_ram_bridge : SPI slave (clk = bit clock) bridging 2-bit-command frames
//                  onto an on-chip RAM with optional address auto-increment.
// Revision 1.0
// ============================================================================
module spi_ram_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_done
);

  localparam int c_FRAME_W = DATA_WIDTH + 2;
  localparam int c_CNT_W   = $clog2(c_FRAME_W);
  localparam int c_TX_W    = $clog2(DATA_WIDTH);
  localparam int c_DEPTH   = 1 << ADDR_WIDTH;

  localparam logic [c_CNT_W-1:0]    c_LAST_BIT  = c_CNT_W'(c_FRAME_W - 1);
  localparam logic [c_TX_W-1:0]     c_LAST_TX   = c_TX_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'((AUTO_INC != 0) ? 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  localparam logic [1:0] c_CMD_WADDR = 2'b00;
  localparam logic [1:0] c_CMD_WRITE = 2'b01;
  localparam logic [1:0] c_CMD_RADDR = 2'b10;
  localparam logic [1:0] c_CMD_READ  = 2'b11;

  logic [1:0]            state_q,    state_d;
  logic [c_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [c_TX_W-1:0]     tx_cnt_q,   tx_cnt_d;
  logic [c_FRAME_W-2:0]  rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-2:0] tx_shift_q, tx_shift_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q,  rd_addr_d;
  logic                  miso_q,     miso_d;
  logic                  done_q,     done_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [c_DEPTH];

  // The frame as it stands once the bit on MOSI is shifted in this edge.
  logic [c_FRAME_W-1:0]  w_frame;
  logic [1:0]            w_cmd;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_last_bit;

  assign w_frame    = {rx_shift_q, MOSI};
  assign w_cmd      = w_frame[c_FRAME_W-1:c_FRAME_W-2];
  assign w_payload  = w_frame[DATA_WIDTH-1:0];
  assign w_rd_word  = mem[rd_addr_q];
  assign w_last_bit = (bit_cnt_q == c_LAST_BIT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      tx_cnt_q   <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
    end
  end

  // Storage is deliberately left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[wr_addr_q] <= w_payload;
    end
  end

  // Next-state and command execution
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        tx_cnt_d  = '0;
        if (!SS_n) begin
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (SS_n) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          miso_d    = 1'b0;
        end else begin
          rx_shift_d = w_frame[c_FRAME_W-2:0];
          bit_cnt_d  = bit_cnt_q + c_CNT_W'(1);
          if (w_last_bit) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            case (w_cmd)
              c_CMD_WADDR: wr_addr_d = w_payload[ADDR_WIDTH-1:0];
              c_CMD_WRITE: begin
                mem_we    = 1'b1;
                wr_addr_d = wr_addr_q + c_ADDR_STEP;
              end
              c_CMD_RADDR: rd_addr_d = w_payload[ADDR_WIDTH-1:0];
              c_CMD_READ: begin
                miso_d     = w_rd_word[DATA_WIDTH-1];
                tx_shift_d = w_rd_word[DATA_WIDTH-2:0];
                tx_cnt_d   = '0;
                rd_addr_d  = rd_addr_q + c_ADDR_STEP;
                state_d    = S_SEND;
              end
              default: ;
            endcase
          end
        end
      end

      S_SEND: begin
        if (SS_n) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          miso_d    = 1'b0;
        end else if (tx_cnt_q == c_LAST_TX) begin
          state_d   = S_RECV;
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
          miso_d    = 1'b0;
        end else begin
          miso_d     = tx_shift_q[DATA_WIDTH-2];
          tx_shift_d = tx_shift_q << 1;
          tx_cnt_d   = tx_cnt_q + c_TX_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
        tx_cnt_d  = '0;
        miso_d    = 1'b0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q != S_IDLE);
    MISO       = miso_q;
    frame_done = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spi_ram_bridge : scoreboard bench for three bridge configurations.
// Revision 1.0
// ============================================================================
module tb_spi_ram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] ss;
  logic [2:0] mosi;
  logic [2:0] rstv;
  wire  [2:0] miso_w;
  wire  [2:0] busy_w;
  wire  [2:0] fd_w;

  spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1)) u_dut0 (
    .clk(clk), .rst(rstv[0]), .SS_n(ss[0]), .MOSI(mosi[0]),
    .MISO(miso_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  spi_ram_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(0)) u_dut1 (
    .clk(clk), .rst(rstv[1]), .SS_n(ss[1]), .MOSI(mosi[1]),
    .MISO(miso_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  spi_ram_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_INC(1)) u_dut2 (
    .clk(clk), .rst(rstv[2]), .SS_n(ss[2]), .MOSI(mosi[2]),
    .MISO(miso_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  function automatic int cw(input int k); return (k == 2) ? 16 : 8; endfunction
  function automatic int ca(input int k); return (k == 2) ? 4 : 8;  endfunction
  function automatic int ci(input int k); return (k == 1) ? 0 : 1;  endfunction

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
    logic [4:0]  nb;
  } exp_t;

  exp_t        expq [3][$];
  logic [15:0] mem_m [3][256];
  int unsigned wra [3];
  int unsigned rda [3];
  bit          sess [3];
  bit          mon_en = 1'b0;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  // One bit-clock period of stimulus on DUT k.
  task automatic cyc(input int k, input logic s, input logic m, input logic r);
    ss[k]   = s;
    mosi[k] = m;
    rstv[k] = r;
    @(negedge clk);
  endtask

  task automatic desel(input int k);
    cyc(k, 1'b1, 1'b0, 1'b0);
    sess[k] = 1'b0;
  endtask

  // One frame; optional abort (SS_n or rst) at frame bit ab_at, or at read bit sab.
  task automatic do_frame(input int k, input logic [1:0] cmd, input int unsigned p,
                          input int ab_at = -1, input bit ab_rst = 1'b0,
                          input int sab = -1, input bit srst = 1'b0);
    int          w;
    int          f;
    int unsigned am;
    int unsigned dm;
    logic [31:0] fv;
    exp_t        e;
    w  = cw(k);
    f  = w + 2;
    am = (32'd1 << ca(k)) - 1;
    dm = (32'd1 << w) - 1;
    fv = ({30'd0, cmd} << w) | (p & dm);
    if (!sess[k]) begin
      cyc(k, 1'b0, 1'($urandom), 1'b0);
      sess[k] = 1'b1;
    end
    for (int i = 0; i < f; i++) begin
      if (i == ab_at) begin
        if (ab_rst) begin
          cyc(k, 1'b0, 1'($urandom), 1'b1);
          wra[k] = 0;
          rda[k] = 0;
        end else begin
          cyc(k, 1'b1, 1'($urandom), 1'b0);
        end
        sess[k] = 1'b0;
        return;
      end
      if (i == f - 1) begin
        e = '0;
        e.rd = (cmd == 2'b11);
        case (cmd)
          2'b00: wra[k] = p & am;
          2'b01: begin
            mem_m[k][wra[k]] = 16'(p & dm);
            wra[k] = (wra[k] + ci(k)) & am;
          end
          2'b10: rda[k] = p & am;
          default: begin
            e.data = mem_m[k][rda[k]];
            rda[k] = (rda[k] + ci(k)) & am;
          end
        endcase
        e.nb = (sab >= 0 && sab < w) ? 5'(sab + 1) : 5'(w);
        expq[k].push_back(e);
      end
      cyc(k, 1'b0, fv[f-1-i], 1'b0);
    end
    if (cmd == 2'b11) begin
      for (int j = 0; j < w; j++) begin
        if (j == sab) begin
          if (srst) begin
            cyc(k, 1'b0, 1'($urandom), 1'b1);
            wra[k] = 0;
            rda[k] = 0;
          end else begin
            cyc(k, 1'b1, 1'($urandom), 1'b0);
          end
          sess[k] = 1'b0;
          return;
        end
        cyc(k, 1'b0, 1'($urandom), 1'b0);
      end
    end
  endtask

  task automatic rand_phase(input int k, input int nops);
    int w;
    int f;
    for (int a = 0; a < (1 << ca(k)); a++) begin
      if (a == 0) do_frame(k, 2'b00, 0);
      do_frame(k, 2'b01, $urandom);
    end
    w = cw(k);
    f = w + 2;
    for (int n = 0; n < nops; n++) begin
      logic [1:0] cmd;
      int ab_at;
      int sab;
      cmd   = 2'($urandom_range(0, 3));
      ab_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, f - 1)) : -1;
      sab   = (cmd == 2'b11 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, w - 1)) : -1;
      do_frame(k, cmd, $urandom, ab_at, 1'($urandom_range(0, 1)), sab, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 7) == 0) begin
        desel(k);
        repeat ($urandom_range(0, 3)) cyc(k, 1'b1, 1'b0, 1'b0);
      end
    end
    desel(k);
  endtask

  // Per-DUT monitor: every frame_done pops one expectation; reads then stream MISO.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int MW = (g == 2) ? 16 : 8;
    int   left = 0;
    int   idx  = 0;
    bit   post = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
      if (mon_en) begin
        if (left > 0) begin
          chk(g, "miso_bit", {31'd0, miso_w[g]}, {31'd0, cur.data[MW-1-idx]});
          idx++;
          left--;
          if (left == 0 && int'(cur.nb) < MW) post = 1'b1;
        end else if (post) begin
          chk(g, "abort_busy", {31'd0, busy_w[g]}, 32'd0);
          chk(g, "abort_miso", {31'd0, miso_w[g]}, 32'd0);
          post = 1'b0;
        end else if (fd_w[g]) begin
          if (expq[g].size() == 0) begin
            chk(g, "unexpected_frame_done", 32'd1, 32'd0);
          end else begin
            cur = expq[g].pop_front();
            if (cur.rd) begin
              chk(g, "miso_msb", {31'd0, miso_w[g]}, {31'd0, cur.data[MW-1]});
              idx  = 1;
              left = int'(cur.nb) - 1;
              if (left == 0 && int'(cur.nb) < MW) post = 1'b1;
            end else begin
              chk(g, "miso_after_cmd", {31'd0, miso_w[g]}, 32'd0);
            end
          end
        end else begin
          chk(g, "miso_idle", {31'd0, miso_w[g]}, 32'd0);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ss   = 3'b111;
    mosi = 3'b000;
    rstv = 3'b111;
    for (int k = 0; k < 3; k++) begin
      sess[k] = 1'b0;
      wra[k]  = 0;
      rda[k]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(k, "reset_busy", {31'd0, busy_w[k]}, 32'd0);
      chk(k, "reset_miso", {31'd0, miso_w[k]}, 32'd0);
      chk(k, "reset_frame_done", {31'd0, fd_w[k]}, 32'd0);
    end
    rstv = 3'b000;
    @(negedge clk);
    mon_en = 1'b1;

    // Single write/read: expect 0xA5 on MISO
    do_frame(0, 2'b00, 'h05);
    do_frame(0, 2'b01, 'hA5);
    do_frame(0, 2'b10, 'h05);
    do_frame(0, 2'b11, 'h00);
    desel(0);
    // Auto-increment burst wrapping 0xFF -> 0x00
    do_frame(0, 2'b00, 'hFE);
    do_frame(0, 2'b01, 'h11);
    do_frame(0, 2'b01, 'h22);
    do_frame(0, 2'b01, 'h33);
    do_frame(0, 2'b10, 'hFE);
    repeat (3) do_frame(0, 2'b11, 0);
    desel(0);
    // Abort after 6 bits of a write, then prove wr_addr stayed at 0x11
    do_frame(0, 2'b00, 'h10);
    do_frame(0, 2'b01, 'h55);
    do_frame(0, 2'b01, 'h99, 6);
    do_frame(0, 2'b10, 'h10);
    do_frame(0, 2'b11, 0);
    do_frame(0, 2'b01, 'h77);
    do_frame(0, 2'b10, 'h11);
    do_frame(0, 2'b11, 0);
    // Reset during the 3rd MISO bit, then addresses are 0 and memory kept
    do_frame(0, 2'b10, 'h10);
    do_frame(0, 2'b11, 0, -1, 1'b0, 2, 1'b1);
    do_frame(0, 2'b11, 0);
    do_frame(0, 2'b01, 'h3C);
    do_frame(0, 2'b10, 'h00);
    do_frame(0, 2'b11, 0);
    do_frame(0, 2'b10, 'h10);
    do_frame(0, 2'b11, 0);
    desel(0);

    // AUTO_INC=0 burst: every write lands on 0xFE
    do_frame(1, 2'b00, 'hFE);
    do_frame(1, 2'b01, 'h11);
    do_frame(1, 2'b01, 'h22);
    do_frame(1, 2'b01, 'h33);
    do_frame(1, 2'b10, 'hFE);
    repeat (3) do_frame(1, 2'b11, 0);
    desel(1);

    // 16-bit data, 4-bit address: 0x0013 aliases address 3
    do_frame(2, 2'b00, 'h0003);
    do_frame(2, 2'b01, 'hBEEF);
    do_frame(2, 2'b10, 'h0013);
    do_frame(2, 2'b11, 0);
    desel(2);

    rand_phase(0, 200);
    rand_phase(2, 150);

    repeat (24) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(k, "queue_drained", expq[k].size(), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_bridge.md
Name: spi_ram_bridge

Overview:
- Parametrised SPI-slave-to-RAM bridge.
- Next generation of the fixed 10-bit SPI slave plus 8-bit RAM pair. It folds both into one block.
- Generalised in data and address width, and adds multi-frame bursts within one SS_n assertion and optional address auto-increment.
- Sits between the external SPI master pins and on-chip storage. The SPI bit clock is the system clock clk.

Parameters:
- DATA_WIDTH, 8: RAM word width W. Frame payload width.
- ADDR_WIDTH, 8: RAM address width. Depth = 2**ADDR_WIDTH. Must satisfy ADDR_WIDTH <= DATA_WIDTH.
- AUTO_INC, 1: 1 = wr_addr/rd_addr post-increment after each data access. 0 = hold.

Ports:
- clk  in  1  system and SPI bit clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse on the edge following a complete command frame.

Behaviour:
- Frame: F = DATA_WIDTH+2 bits, MSB first. cmd = bits[F-1:F-2], payload P = bits[W-1:0].
- Commands:
  - 00: wr_addr <= P[ADDR_WIDTH-1:0].
  - 01: mem[wr_addr] <= P. Then wr_addr+1 if AUTO_INC, mod 2**ADDR_WIDTH.
  - 10: rd_addr <= P[ADDR_WIDTH-1:0].
  - 11: read. P is dummy. Send mem[rd_addr]. Then rd_addr+1 if AUTO_INC, wrapping.
- States: IDLE, RECV, SEND.
- IDLE:
  - The first edge with SS_n=0 moves to RECV with bit_cnt=0. MOSI is not sampled on that edge.
  - While in IDLE, MISO=0.
- RECV:
  - Each edge shifts MOSI into rx_shift, bit_cnt+1.
  - On the edge sampling bit F-1 (last), the command executes on that same edge (address/memory updates visible next cycle). frame_done pulses next cycle.
  - Cmd 00/01/10: stay in RECV with bit_cnt=0. The next edge samples the first bit of the next frame (back-to-back bursts, no gap).
  - Cmd 11: on the last-bit edge, MISO <= mem[rd_addr][W-1] and tx_shift <= remaining bits. Go to SEND with tx_cnt=0.
- SEND:
  - MISO holds each bit for one cycle. The MSB is valid in the cycle after the last command bit; W bits total over W consecutive cycles.
  - Each edge shifts the next bit out, tx_cnt+1.
  - After W bits are presented, return to RECV with bit_cnt=0. MISO <= 0.
  - MOSI is ignored in SEND.
- SS_n=1 on any edge in RECV/SEND: next state IDLE, counters cleared, MISO <= 0.
  - A partial frame is discarded with no address or memory effect. A partially sent read is abandoned, but rd_addr has already incremented.
- Reset (rst=1 on edge) overrides everything:
  - state=IDLE, bit_cnt=0, tx_cnt=0, wr_addr=0, rd_addr=0, MISO=0, busy=0, frame_done=0.
  - Memory contents are not cleared.
  - Reset mid-frame aborts with no side effects.
- Simultaneous events: SS_n rising on the last-bit edge aborts; the command does not execute. rst beats SS_n.
- Write-then-read of the same address across frames returns the new data (RAM updated before the next frame's read edge).
- Reads of never-written addresses after power-up are undefined (X in simulation). The bench must write before reading.

Test Plan:
- Defaults, single write/read:
  - Stimulus: frames 00_0x05, 01_0xA5, 10_0x05, 11_0x00 in one SS_n low.
  - Response: frame_done pulses 4 times; MISO = 1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after the 40th bit.
- Auto-increment burst with AUTO_INC=1:
  - Stimulus: 00_0xFE, then 01 with 0x11, 0x22, 0x33; then 10_0xFE, 11 x3.
  - Response: mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap); reads return 0x11, 0x22, 0x33.
- AUTO_INC=0:
  - Stimulus: same as the burst case.
  - Response: mem[0xFE]=0x33; all three reads return 0x33.
- Abort:
  - Stimulus: after 00_0x10 and 01_0x55, SS_n rises after 6 bits of 01_0x99; reselect; read 0x10.
  - Response: 0x55 returned; wr_addr=0x11 (unchanged by the aborted frame).
- Reset mid-SEND:
  - Stimulus: rst=1 during the 3rd MISO bit.
  - Response: MISO=0, busy=0 next cycle; wr_addr=rd_addr=0; memory contents retained on subsequent read.
- Width variant DATA_WIDTH=16, ADDR_WIDTH=4:
  - Stimulus: 00_0x0003, 01_0xBEEF, 10_0x0013, 11.
  - Response: 0xBEEF returned, since only the low 4 address bits are used; 16-bit MISO sequence.
